// File: rtl/viterbi_decoder_param.sv
// Hard-decision Viterbi decoder for a rate-1/2 convolutional code.
// Decodes one received symbol at a time: an ACS over all states, one survivor
// column stored per symbol, then a sliding-window traceback emits the oldest bit.
// A frame ending with in_last is flushed so that every accepted symbol yields
// exactly one decoded bit.
module viterbi_decoder_param #(
  parameter int           K    = 3,
  parameter logic [K-1:0] G0   = 3'b111,
  parameter logic [K-1:0] G1   = 3'b101,
  parameter int           TB   = 15,
  parameter int           PM_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_sym,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  output logic            out_last,
  output logic [PM_W-1:0] best_metric
);
  localparam int NS = 1 << (K - 1);
  localparam int SW = K - 1;
  localparam int PW = $clog2(TB);
  localparam int FW = $clog2(TB + 1);
  localparam logic [PM_W-1:0] PM_INIT = {2'b01, {(PM_W - 2){1'b0}}};

  typedef enum logic [1:0] {ST_ACCEPT, ST_ACS, ST_TRACE, ST_EMIT} state_t;

  state_t          state;
  logic [PM_W-1:0] pm [NS];
  logic [NS-1:0]   surv [TB];
  logic [PW-1:0]   wr_ptr, tr_col;
  logic [FW-1:0]   fill, tr_cnt;
  logic            flush;
  logic [1:0]      sym_q;
  logic [SW-1:0]   tr_state, best_state;

  logic [PM_W-1:0] cand0 [NS];
  logic [PM_W-1:0] cand1 [NS];
  logic [PM_W-1:0] pm_raw [NS];
  logic [PM_W-1:0] pm_new [NS];
  logic [NS-1:0]   dec_col;
  logic            all_msb;
  logic [PM_W-1:0] min_val;
  logic [SW-1:0]   min_state;
  logic [FW-1:0]   fill_inc, fill_dec;
  logic            tr_dec;
  logic [SW-1:0]   tr_next;

  // Predecessor of a state: drop the newest input, append the bit shifted out.
  function automatic logic [SW-1:0] pred_of(input logic [SW-1:0] st, input logic b);
    return {st[SW-2:0], b};
  endfunction

  // Hamming distance between the received pair and the branch prv -> nxt.
  function automatic logic [1:0] branch_metric(input logic [SW-1:0] nxt,
                                               input logic [SW-1:0] prv,
                                               input logic [1:0]    sym);
    logic [K-1:0] taps;
    taps = {nxt[SW-1], prv};
    return {1'b0, sym[1] ^ (^(G0 & taps))} + {1'b0, sym[0] ^ (^(G1 & taps))};
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(TB - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(TB - 1) : p - PW'(1);
  endfunction

  assign in_ready = (state == ST_ACCEPT);
  assign fill_inc = (fill == FW'(TB)) ? fill : fill + FW'(1);
  assign fill_dec = fill - FW'(1);
  assign tr_dec   = surv[tr_col][tr_state];
  assign tr_next  = (tr_cnt != '0) ? pred_of(tr_state, tr_dec) : tr_state;

  // ACS for all states, shared normalisation, and lowest-metric state search.
  // NOTE: combinational blocks use blocking '=' and give every output a value
  // on every path (defaults first), so no latch is inferred.
  always_comb begin
    all_msb   = 1'b1;
    min_val   = '0;
    min_state = '0;
    for (int s = 0; s < NS; s++) begin
      cand0[s]   = pm[pred_of(SW'(s), 1'b0)]
                 + PM_W'(branch_metric(SW'(s), pred_of(SW'(s), 1'b0), sym_q));
      cand1[s]   = pm[pred_of(SW'(s), 1'b1)]
                 + PM_W'(branch_metric(SW'(s), pred_of(SW'(s), 1'b1), sym_q));
      dec_col[s] = (cand1[s] < cand0[s]);
      pm_raw[s]  = dec_col[s] ? cand1[s] : cand0[s];
      all_msb    = all_msb & pm_raw[s][PM_W-1];
    end
    for (int s = 0; s < NS; s++) begin
      pm_new[s] = pm_raw[s];
      if (all_msb) pm_new[s][PM_W-1] = 1'b0;
    end
    min_val = pm_new[0];
    for (int s = 1; s < NS; s++) begin
      if (pm_new[s] < min_val) begin
        min_val   = pm_new[s];
        min_state = SW'(s);
      end
    end
  end

  // Survivor window: one decision column written per ACS.
  // NOTE: the survivor memory has no reset; fill tracks which columns hold
  // live decisions, so stale columns are never traced.
  always_ff @(posedge clk) begin
    if (state == ST_ACS) surv[wr_ptr] <= dec_col;
  end

  // Control FSM with path metrics, window pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ACCEPT;
      for (int s = 0; s < NS; s++) pm[s] <= (s == 0) ? '0 : PM_INIT;
      wr_ptr      <= '0;
      fill        <= '0;
      flush       <= 1'b0;
      sym_q       <= '0;
      tr_col      <= '0;
      tr_cnt      <= '0;
      tr_state    <= '0;
      best_state  <= '0;
      best_metric <= '0;
      out_valid   <= 1'b0;
      out_bit     <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      case (state)
        ST_ACCEPT: begin
          if (in_valid) begin
            sym_q <= in_sym;
            flush <= in_last;
            state <= ST_ACS;
          end
        end
        ST_ACS: begin
          for (int s = 0; s < NS; s++) pm[s] <= pm_new[s];
          best_metric <= min_val;
          best_state  <= min_state;
          wr_ptr      <= ptr_inc(wr_ptr);
          fill        <= fill_inc;
          if (fill_inc == FW'(TB) || flush) begin
            tr_col   <= wr_ptr;
            tr_state <= min_state;
            tr_cnt   <= fill_inc - FW'(1);
            state    <= ST_TRACE;
          end else begin
            state <= ST_ACCEPT;
          end
        end
        ST_TRACE: begin
          // The final step goes straight to the output register.
          if (tr_cnt <= FW'(1)) begin
            out_bit   <= tr_next[SW-1];
            out_last  <= flush && (fill == FW'(1));
            out_valid <= 1'b1;
            state     <= ST_EMIT;
          end else begin
            tr_state <= tr_next;
            tr_col   <= ptr_dec(tr_col);
            tr_cnt   <= tr_cnt - FW'(1);
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            fill      <= fill_dec;
            if (flush && fill_dec != '0) begin
              tr_col   <= ptr_dec(wr_ptr);
              tr_state <= best_state;
              tr_cnt   <= fill_dec - FW'(1);
              state    <= ST_TRACE;
            end else if (flush) begin
              for (int s = 0; s < NS; s++) pm[s] <= (s == 0) ? '0 : PM_INIT;
              wr_ptr <= '0;
              flush  <= 1'b0;
              state  <= ST_ACCEPT;
            end else begin
              state <= ST_ACCEPT;
            end
          end
        end
        default: state <= ST_ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_decoder_param.sv
// Scoreboard bench for viterbi_decoder_param (K=3, generators 7/5, TB=15).
// Stimulus pushes the source bit of every accepted symbol; a monitor pops and
// compares each decoded bit when the decoder presents it.
module tb_viterbi_decoder_param;
  localparam int K    = 3;
  localparam int TB   = 15;
  localparam int PM_W = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      in_sym = 2'b00;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_bit;
  logic            out_last;
  logic [PM_W-1:0] best_metric;

  viterbi_decoder_param #(
    .K(K), .G0(3'b111), .G1(3'b101), .TB(TB), .PM_W(PM_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sym(in_sym), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_bit(out_bit), .out_last(out_last),
    .best_metric(best_metric)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic data;
    logic last;
    int   acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   acc_count = 0;
  int   stall_req = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference rate-1/2 encoder, generators 111 and 101, newest input in MSB.
  function automatic logic [1:0] enc(input logic u, input logic [1:0] s);
    logic [2:0] r;
    r = {u, s};
    return {^(r & 3'b111), ^(r & 3'b101)};
  endfunction

  // Present one symbol, wait for acceptance, record the expected decoded bit.
  task automatic send(input logic [1:0] sym, input logic last, input logic data,
                      input int idx, input int len);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      $display("FAIL in_ready_timeout: in_ready=%0d expected 1", in_ready);
      $fatal(1);
    end
    in_sym   = sym;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    acc_count++;
    sb.push_back('{data, last, (idx + TB < len) ? idx + TB : len});
  endtask

  // Encode a frame; optionally flip G0 bits periodically (never in the last 20).
  task automatic send_encoded(input int len, input logic all_ones, input int err_period,
                              input int err_phase, input int stall_idx, output int n_err);
    logic [1:0] s;
    logic [1:0] sym;
    logic       u;
    s = 2'b00;
    n_err = 0;
    acc_count = 0;
    for (int i = 0; i < len; i++) begin
      u   = all_ones ? 1'b1 : 1'($urandom_range(0, 1));
      sym = enc(u, s);
      s   = {u, s[1]};
      if (err_period > 0 && (i % err_period) == err_phase && i < len - 20) begin
        sym[1] = ~sym[1];
        n_err++;
      end
      if (i == stall_idx) stall_req = 20;
      send(sym, i == len - 1, u, i, len);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_table(input logic [1:0] syms [4]);
    logic [3:0] bits;
    bits = 4'b1101;
    acc_count = 0;
    for (int i = 0; i < 4; i++) send(syms[i], i == 3, bits[i], i, 4);
  endtask

  // Monitor: pops one expectation per presented bit; optional sink stall.
  initial begin : monitor
    exp_t e;
    logic held_bit;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (stall_req > 0) begin
          held_bit  = out_bit;
          out_ready = 1'b0;
          for (int i = 0; i < stall_req; i++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_bit", out_bit, held_bit);
            check("stall_in_ready", in_ready, 0);
          end
          stall_req = 0;
          out_ready = 1'b1;
        end
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output: got out_bit=%0d with no expected bit", out_bit);
        end else begin
          e = sb.pop_front();
          check("out_bit", out_bit, e.data);
          check("out_last", out_last, e.last);
          check("accepted_at_emit", acc_count, e.acc);
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    logic [1:0] frame_a [4];
    logic [1:0] frame_b [4];
    int         n_err;
    logic [1:0] s;
    logic [1:0] sym;
    logic       u;

    frame_a = '{2'b11, 2'b10, 2'b00, 2'b01};
    frame_b = '{2'b11, 2'b00, 2'b00, 2'b01};

    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_last", out_last, 0);
    check("rst_best_metric", best_metric, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Clean four-symbol frame, then the same with one channel bit error.
    send_table(frame_a);
    drain("frame_a");
    check("frame_a_metric", best_metric, 0);
    send_table(frame_b);
    drain("frame_b");
    check("frame_b_metric", best_metric, 1);

    // 40 random bits, error-free, with a 20-cycle sink stall mid-frame.
    send_encoded(40, 1'b0, 0, 0, 18, n_err);
    drain("random40");
    check("random40_metric", best_metric, 0);

    // Long noisy all-ones frame: metric must wrap through normalisation.
    send_encoded(2000, 1'b1, 20, 7, -1, n_err);
    drain("noisy2000");
    check("noisy2000_metric", best_metric, n_err % (1 << (PM_W - 1)));

    // Reset while the decoder is tracing back, then a fresh frame.
    s = 2'b00;
    acc_count = 0;
    for (int i = 0; i < TB; i++) begin
      u   = 1'($urandom_range(0, 1));
      sym = enc(u, s);
      s   = {u, s[1]};
      if (i == 3) sym[0] = ~sym[0];
      send(sym, 1'b0, u, i, 100);
    end
    repeat (4) @(negedge clk);
    check("pre_reset_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_bit", out_bit, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_best_metric", best_metric, 0);
    sb.delete();
    acc_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    send_table(frame_a);
    drain("post_reset");
    check("post_reset_metric", best_metric, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
